dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LENGTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 10, word-index width; storage depth is 2^ADDR_BITS words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each response (legal range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  LENGTH  byte address.
REQ-010 SHALL have port req_wdata  input  LENGTH  store data.
REQ-011 SHALL have port req_be  input  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  the initiator consumes the response.
REQ-014 SHALL have port resp_rdata  output  LENGTH  load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  the request was misaligned or out of range.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Handshake SHALL complete when req_valid && req_ready; the responder latches we/addr/wdata/be on that edge.
REQ-018 From IDLE with an accepted request: go to WAIT if WAIT_CYCLES > 0, else go to RESP.
REQ-019 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit down-counter, then enter RESP; resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after acceptance.
REQ-020 Store commit and load sampling SHALL occur on the edge entering RESP; resp_rdata SHALL be registered and held stable while resp_valid = 1.
REQ-021 RESP SHALL hold resp_valid = 1 until resp_valid && resp_ready, then return to IDLE; a new request is accepted no earlier than the following cycle (max throughput = one request per WAIT_CYCLES+2 cycles).
REQ-022 An error SHALL be flagged when req_addr[1:0] != 0 or req_addr[LENGTH-1:ADDR_BITS+2] != 0; on error, no store occurs, resp_rdata = 0 and resp_err = 1.
REQ-023 Word index SHALL be req_addr[ADDR_BITS+1:2]; the highest index 2^ADDR_BITS-1 SHALL be legal.
REQ-024 A store with req_be = 0 SHALL complete normally and write nothing.
REQ-025 Request inputs SHALL be ignored outside IDLE; req_valid held high during WAIT/RESP is not a second request.

Reset
REQ-026 On rst = 1 at a clock edge: state = IDLE, counter = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0; req_ready SHALL read 1 in the first cycle after reset.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 Reset in WAIT SHALL discard the pending store (no write); reset in RESP SHALL drop the response.
REQ-029 If rst and req_valid are both high, the request SHALL NOT be accepted.

Configuration
REQ-030 With macro DMEM_BYTE_EN defined, stores SHALL write only the bytes whose req_be bit is 1.
REQ-031 Without DMEM_BYTE_EN, req_be SHALL be ignored and every error-free store SHALL write the full word.

Verification
REQ-032 WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF accepted at cycle T -> resp_valid at T+3, resp_err 0; then load 0x10 -> resp_rdata 0xDEADBEEF.
REQ-033 DMEM_BYTE_EN defined: word 0x20 = 0x11223344, store be=4'b0101 data 0xAABBCCDD -> load returns 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-034 Load at addr 0x13 (misaligned) and at addr 0x00001000 with ADDR_BITS=10 (out of range) -> resp_err 1, resp_rdata 0, storage unchanged.
REQ-035 resp_ready held 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready 0 throughout; ready pulse -> IDLE on the next cycle.
REQ-036 rst asserted one cycle after accepting a store to 0x40 -> after reset, load 0x40 returns the old value, and resp_valid is 0 right after reset.
REQ-037 WAIT_CYCLES=0: back-to-back requests with resp_ready tied 1 -> each response one cycle after acceptance, one accept per 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request and
// response handshake, with a fixed number of wait states per access.
// Optional feature macro: DMEM_BYTE_EN. When it is defined, stores honour
// req_be per byte. When it is undefined, every error-free store writes the
// full word.
// Storage is deliberately left out of reset, so its contents survive rst.
//
// state | meaning
// IDLE  | ready for a request (req_ready = 1)
// WAIT  | wait states pending; counter counts down to zero
// RESP  | response presented until resp_ready
module dmem_responder #(
    parameter int LENGTH      = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [LENGTH-1:0] req_addr,
    input  logic [LENGTH-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LENGTH-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic                   lat_we;
    logic [LENGTH-1:0]      lat_addr;
    logic [LENGTH-1:0]      lat_wdata;
    logic [LENGTH-1:0]      mem [DEPTH];

    logic                   op_we;
    logic [LENGTH-1:0]      op_addr;
    logic [LENGTH-1:0]      op_wdata;
    logic                   op_err;
    logic [ADDR_BITS-1:0]   op_idx;
    logic [LENGTH-1:0]      wmask;
    logic                   enter_resp;
    logic                   commit;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used in IDLE and the latched copy otherwise.
    assign op_we    = (state == IDLE) ? req_we    : lat_we;
    assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign op_idx   = op_addr[ADDR_BITS+1:2];
    assign op_err   = (op_addr[1:0] != 2'b00) || (op_addr[LENGTH-1:ADDR_BITS+2] != '0);

    assign enter_resp = !rst &&
                        (((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && (cnt == 4'd0)));
    assign commit     = enter_resp && op_we && !op_err;

`ifdef DMEM_BYTE_EN
    logic [3:0] lat_be;
    logic [3:0] op_be;

    assign op_be = (state == IDLE) ? req_be : lat_be;

    // Capture byte enables alongside the rest of the request.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid && !rst) begin
            lat_be <= req_be;
        end
    end

    // Expand byte enables into a bit mask; lanes beyond LENGTH stay clear.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) begin
            if (8 * i + 8 <= LENGTH) begin
                wmask[8*i +: 8] = {8{op_be[i]}};
            end
        end
    end
`else
    logic unused_be;

    assign unused_be = ^req_be;
    assign wmask     = '1;
`endif

    // Store commit on the edge that enters RESP; a reset on that edge suppresses it.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[op_idx] <= (mem[op_idx] & ~wmask) | (op_wdata & wmask);
        end
    end

    // Handshake FSM with registered request-ready and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase

            if (enter_resp) begin
                resp_valid <= 1'b1;
                resp_err   <= op_err;
                resp_rdata <= (op_err || op_we) ? '0 : mem[op_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = 4'hF;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid1 = 1'b0, req_we1 = 1'b0;
    logic        resp_ready1 = 1'b1;
    logic [31:0] req_addr1 = '0, req_wdata1 = '0;
    logic [3:0]  req_be1 = 4'hF;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    int checks = 0;
    int fails  = 0;

    logic [31:0] rd;
    logic        er;
    int          lt;

    always #5 clk = ~clk;

    dmem_responder #(.LENGTH(32), .ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.LENGTH(32), .ADDR_BITS(10), .WAIT_CYCLES(0)) dut0w (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    // One full transaction on the two-wait-state instance; lat counts negedges
    // from acceptance to the first one showing resp_valid (-1 on timeout).
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            rdata = resp_rdata;
            err   = resp_err;
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (req_ready1 !== 1'b1) begin fails++; $display("FAIL reset_req_ready_w0 got %b want 1", req_ready1); end
    endtask

    task automatic test_store_load();
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lt);
        checks++; if (lt !== 3) begin fails++; $display("FAIL store_latency got %0d want 3", lt); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL store_err got %b want 0", er); end
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
        checks++; if (lt !== 3) begin fails++; $display("FAIL load_latency got %0d want 3", lt); end
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL load_err got %b want 0", er); end
        xact(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lt);
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL top_index_store_err got %b want 0", er); end
        xact(1'b0, 32'hFFC, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL top_index_load got %h want cafef00d", rd); end
    endtask

    task automatic test_byte_en();
        logic [31:0] exp_mix, exp_zero;
`ifdef DMEM_BYTE_EN
        exp_mix  = 32'h11BB33DD;
        exp_zero = 32'h13579BDF;
`else
        exp_mix  = 32'hAABBCCDD;
        exp_zero = 32'h0BADF00D;
`endif
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lt);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lt);
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== exp_mix) begin fails++; $display("FAIL byte_en_mix got %h want %h", rd, exp_mix); end
        xact(1'b1, 32'h24, 32'h13579BDF, 4'hF, rd, er, lt);
        xact(1'b1, 32'h24, 32'h0BADF00D, 4'b0000, rd, er, lt);
        checks++; if (lt !== 3) begin fails++; $display("FAIL be_zero_latency got %0d want 3", lt); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL be_zero_err got %b want 0", er); end
        xact(1'b0, 32'h24, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== exp_zero) begin fails++; $display("FAIL be_zero_load got %h want %h", rd, exp_zero); end
    endtask

    task automatic test_errors();
        xact(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lt);
        xact(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lt);
        checks++; if (er !== 1'b1) begin fails++; $display("FAIL misaligned_load_err got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL misaligned_load_rdata got %h want 0", rd); end
        xact(1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lt);
        checks++; if (er !== 1'b1) begin fails++; $display("FAIL range_load_err got %b want 1", er); end
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL range_load_rdata got %h want 0", rd); end
        checks++; if (lt !== 3) begin fails++; $display("FAIL range_load_latency got %0d want 3", lt); end
        xact(1'b1, 32'h31, 32'hFFFFFFFF, 4'hF, rd, er, lt);
        checks++; if (er !== 1'b1) begin fails++; $display("FAIL misaligned_store_err got %b want 1", er); end
        xact(1'b1, 32'h1030, 32'hEEEEEEEE, 4'hF, rd, er, lt);
        checks++; if (er !== 1'b1) begin fails++; $display("FAIL range_store_err got %b want 1", er); end
        xact(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== 32'h12345678) begin fails++; $display("FAIL error_storage_intact got %h want 12345678", rd); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL aligned_after_err got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(posedge clk);
        #1 req_we = 1'b1; req_wdata = 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 50);
        checks++; if (n !== 3) begin fails++; $display("FAIL bp_latency got %0d want 3", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_hold[%0d] got %b want 1", i, resp_valid); end
            checks++; if (resp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_rdata_hold[%0d] got %h want deadbeef", i, resp_rdata); end
            checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_back_idle got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got %b want 0", resp_valid); end
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL bp_no_stray_store got %h want deadbeef", rd); end
    endtask

    task automatic test_reset_mid();
        int n;
        xact(1'b1, 32'h40, 32'h55555555, 4'hF, rd, er, lt);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h99999999; req_be = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1; req_wdata = 32'h77777777;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_valid[%0d] got %b want 0", i, resp_valid); end
            checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_wait_ready[%0d] got %b want 1", i, req_ready); end
        end
        xact(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lt);
        checks++; if (rd !== 32'h55555555) begin fails++; $display("FAIL rst_discard_store got %h want 55555555", rd); end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 50);
        checks++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL rst_resp_reach got %b want 1", resp_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_drop got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (req_ready1 !== (k % 2 == 0)) begin fails++; $display("FAIL b2b_ready[%0d] got %b want %b", k, req_ready1, (k % 2 == 0)); end
            checks++; if (resp_valid1 !== (k % 2 == 1)) begin fails++; $display("FAIL b2b_valid[%0d] got %b want %b", k, resp_valid1, (k % 2 == 1)); end
            if (k % 2 == 0) begin
                req_valid1 = 1'b1;
                req_be1    = 4'hF;
                case (k / 2)
                    0: begin req_we1 = 1'b1; req_addr1 = 32'h0; req_wdata1 = 32'hA5A5A5A5; end
                    1: begin req_we1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; end
                    2: begin req_we1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'h0F0F0F0F; end
                    default: begin req_we1 = 1'b0; req_addr1 = 32'h4; req_wdata1 = 32'h0; end
                endcase
            end else begin
                case (k / 2)
                    1: exp_rd = 32'hA5A5A5A5;
                    3: exp_rd = 32'h0F0F0F0F;
                    default: exp_rd = 32'h0;
                endcase
                checks++; if (resp_rdata1 !== exp_rd) begin fails++; $display("FAIL b2b_rdata[%0d] got %h want %h", k, resp_rdata1, exp_rd); end
                checks++; if (resp_err1 !== 1'b0) begin fails++; $display("FAIL b2b_err[%0d] got %b want 0", k, resp_err1); end
            end
        end
        req_valid1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_en();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
